multiplexor_16x20_4_20: RTL and testbench

- 16-input, 20-bit-wide selector with a registered output.
- A 4-bit address picks one of sixteen data words (a..p); the chosen word is captured into the output register on each rising clock edge.
- Sits in the datapath wherever one of sixteen 20-bit sources (register-file reads, operand buses) must be steered onto a single bus with a clean, registered timing boundary.

---
 rtl/multiplexor_16x20_4_20_if.sv | 35 +++
 rtl/multiplexor_16x20_4_20.sv | 43 ++++
 tb/tb_multiplexor_16x20_4_20.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/multiplexor_16x20_4_20_if.sv
// Bus bundle for the 16-way 20-bit selector: sixteen data words, the select
// address and the registered result.
interface multiplexor_16x20_4_20_if #(
  parameter int WIDTH = 20,
  parameter int SEL_W = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] l;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] o;
  logic [WIDTH-1:0] p;
  logic [SEL_W-1:0] addr;
  logic [WIDTH-1:0] out;

  modport master (
    output a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p, addr,
    input  out
  );

  modport slave (
    input  a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p, addr,
    output out
  );
endinterface

// File: rtl/multiplexor_16x20_4_20.sv
// Sixteen-input, 20-bit selector with a registered output; addr indexes a..p
// in alphabetical order and the chosen word lands on out one clock later.
module multiplexor_16x20_4_20 #(
  parameter int WIDTH = 20,
  parameter int SEL_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multiplexor_16x20_4_20_if.slave   bus
);

  logic [WIDTH-1:0] words [2**SEL_W];
  logic [WIDTH-1:0] out_q;

  // Table view of the inputs so addr can index them directly; every code is valid.
  assign words[0]  = bus.a;
  assign words[1]  = bus.b;
  assign words[2]  = bus.c;
  assign words[3]  = bus.d;
  assign words[4]  = bus.e;
  assign words[5]  = bus.f;
  assign words[6]  = bus.g;
  assign words[7]  = bus.h;
  assign words[8]  = bus.i;
  assign words[9]  = bus.j;
  assign words[10] = bus.k;
  assign words[11] = bus.l;
  assign words[12] = bus.m;
  assign words[13] = bus.n;
  assign words[14] = bus.o;
  assign words[15] = bus.p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= words[bus.addr];
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_multiplexor_16x20_4_20.sv
// Self-checking bench for multiplexor_16x20_4_20: a table of sixteen words
// models the inputs and the expected output is simply table[addr] one edge later.
module tb_multiplexor_16x20_4_20;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [19:0] model [16];

  multiplexor_16x20_4_20_if bus ();

  multiplexor_16x20_4_20 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic load_inputs();
    bus.a = model[0];  bus.b = model[1];  bus.c = model[2];  bus.d = model[3];
    bus.e = model[4];  bus.f = model[5];  bus.g = model[6];  bus.h = model[7];
    bus.i = model[8];  bus.j = model[9];  bus.k = model[10]; bus.l = model[11];
    bus.m = model[12]; bus.n = model[13]; bus.o = model[14]; bus.p = model[15];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] exp;
    rst_n = 1'b0;
    for (int x = 0; x < 16; x++) model[x] = 20'h0;
    model[0] = 20'hABCDE;
    load_inputs();
    bus.addr = 4'h0;
    #1;
    tests++;
    if (bus.out !== 20'h00000) begin
      $display("[TB] FAIL reset_initial: got %h expected %h", bus.out, 20'h00000);
      fails++;
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      tests++;
      if (bus.out !== 20'h00000) begin
        $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", cyc, bus.out, 20'h00000);
        fails++;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.out !== 20'h00000) begin
      $display("[TB] FAIL reset_release_pre_edge: got %h expected %h", bus.out, 20'h00000);
      fails++;
    end
    tick();
    exp = 20'hABCDE;
    tests++;
    if (bus.out !== exp) begin
      $display("[TB] FAIL reset_release: got %h expected %h", bus.out, exp);
      fails++;
    end
  endtask

  task automatic test_sweep();
    logic [19:0] exp;
    for (int x = 0; x < 16; x++) model[x] = 20'h10000 + 20'(x);
    @(negedge clk);
    load_inputs();
    for (int ad = 0; ad < 16; ad++) begin
      @(negedge clk);
      bus.addr = 4'(ad);
      tick();
      exp = 20'h10000 + 20'(ad);
      tests++;
      if (bus.out !== exp) begin
        $display("[TB] FAIL sweep addr=%0d: got %h expected %h", ad, bus.out, exp);
        fails++;
      end
    end
  endtask

  task automatic test_random_select();
    logic [19:0] exp;
    logic [3:0]  ad;
    for (int x = 0; x < 16; x++) model[x] = 20'($urandom);
    @(negedge clk);
    load_inputs();
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      ad = 4'($urandom_range(0, 15));
      bus.addr = ad;
      exp = model[ad];
      tick();
      tests++;
      if (bus.out !== exp) begin
        $display("[TB] FAIL random_select addr=%0d: got %h expected %h", ad, bus.out, exp);
        fails++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    logic [3:0]  ad;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      for (int x = 0; x < 16; x++) model[x] = 20'($urandom);
      load_inputs();
      ad = 4'($urandom_range(0, 15));
      bus.addr = ad;
      exp = model[ad];
      tick();
      tests++;
      if (bus.out !== exp) begin
        $display("[TB] FAIL back_to_back step %0d addr=%0d: got %h expected %h", t, ad, bus.out, exp);
        fails++;
      end
    end
  endtask

  task automatic test_data_change();
    @(negedge clk);
    model[7] = 20'h00001;
    load_inputs();
    bus.addr = 4'h7;
    tick();
    tests++;
    if (bus.out !== 20'h00001) begin
      $display("[TB] FAIL data_change_first: got %h expected %h", bus.out, 20'h00001);
      fails++;
    end
    #2;
    model[7] = 20'hFFFFF;
    load_inputs();
    #1;
    tests++;
    if (bus.out !== 20'h00001) begin
      $display("[TB] FAIL data_change_mid_cycle: got %h expected %h", bus.out, 20'h00001);
      fails++;
    end
    tick();
    tests++;
    if (bus.out !== 20'hFFFFF) begin
      $display("[TB] FAIL data_change_after_edge: got %h expected %h", bus.out, 20'hFFFFF);
      fails++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    model[3] = 20'h5A5A5;
    load_inputs();
    bus.addr = 4'h3;
    tick();
    tests++;
    if (bus.out !== 20'h5A5A5) begin
      $display("[TB] FAIL async_reset_setup: got %h expected %h", bus.out, 20'h5A5A5);
      fails++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out !== 20'h00000) begin
      $display("[TB] FAIL async_reset_immediate: got %h expected %h", bus.out, 20'h00000);
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.out !== 20'h00000) begin
      $display("[TB] FAIL async_reset_release_pre_edge: got %h expected %h", bus.out, 20'h00000);
      fails++;
    end
    tick();
    tests++;
    if (bus.out !== 20'h5A5A5) begin
      $display("[TB] FAIL async_reset_recover: got %h expected %h", bus.out, 20'h5A5A5);
      fails++;
    end
  endtask

  task automatic test_bit_isolation();
    logic [19:0] exp;
    for (int x = 0; x < 16; x++) model[x] = 20'hFFFFF;
    for (int bit_pos = 0; bit_pos < 20; bit_pos++) begin
      @(negedge clk);
      exp = 20'h0;
      exp[bit_pos] = 1'b1;
      model[14] = exp;
      load_inputs();
      bus.addr = 4'hE;
      tick();
      tests++;
      if (bus.out !== exp) begin
        $display("[TB] FAIL bit_isolation bit=%0d: got %h expected %h", bit_pos, bus.out, exp);
        fails++;
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_sweep();
    test_random_select();
    test_back_to_back();
    test_data_change();
    test_async_reset();
    test_bit_isolation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
